// File: rtl/python_word_align_if.sv
// Word stream bundle (per-lane words, sync word, valid) shared by the raw and aligned
// sides of the PYTHON LVDS word aligner.
interface python_word_align_if #(
    parameter int DATA_LANES = 4,
    parameter int WORD_BITS  = 10
);
    logic [DATA_LANES-1:0][WORD_BITS-1:0] data;
    logic [WORD_BITS-1:0]                 sync;
    logic                                 valid;

    modport master (output data, sync, valid);
    modport slave  (input  data, sync, valid);
endinterface

// File: rtl/python_word_align.sv
// Per-lane 10-bit word aligner for the PYTHON LVDS receive path: finds each lane's bit
// offset from the idle training word, then emits rotated words once every lane is locked.
module python_word_align #(
    parameter int                   DATA_LANES    = 4,
    parameter int                   WORD_BITS     = 10,
    parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = 10'h3a6,
    parameter int                   LOCK_COUNT    = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                restart,
    python_word_align_if.slave  s,
    python_word_align_if.master m,
    output logic [DATA_LANES:0] lane_locked,
    output logic                aligned
);
    localparam int NL = DATA_LANES + 1;
    localparam int OW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [OW-1:0] OFF_MAX  = OW'(WORD_BITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_COUNT - 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} lane_state_t;

    lane_state_t                     state_r    [NL];
    lane_state_t                     state_n_s  [NL];
    logic [OW-1:0]                   offset_r   [NL];
    logic [OW-1:0]                   offset_n_s [NL];
    logic [CW-1:0]                   cnt_r      [NL];
    logic [CW-1:0]                   cnt_n_s    [NL];
    logic [WORD_BITS-1:0]            prev_r     [NL];
    logic [2*WORD_BITS-1:0]          cat_s      [NL];
    logic [NL-1:0][WORD_BITS-1:0]    raw_s;
    logic [NL-1:0][WORD_BITS-1:0]    window_s;
    logic [NL-1:0]                   locked_n_s;

    // The sync lane rides as the topmost lane so all lanes share one search engine.
    assign raw_s = {s.sync, s.data};

    // Window extraction and per-lane search/lock next-state.
    always_comb begin
        for (int i = 0; i < NL; i++) begin
            cat_s[i]      = {raw_s[i], prev_r[i]} >> offset_r[i];
            window_s[i]   = cat_s[i][WORD_BITS-1:0];
            state_n_s[i]  = state_r[i];
            offset_n_s[i] = offset_r[i];
            cnt_n_s[i]    = cnt_r[i];
            if (restart) begin
                // Restart wins over a lock completing on the same edge; offset is kept.
                state_n_s[i] = SEARCH;
                cnt_n_s[i]   = CW'(0);
            end else if (s.valid) begin
                case (state_r[i])
                    SEARCH: begin
                        if (window_s[i] == TRAIN_PATTERN) begin
                            if (cnt_r[i] == CNT_LAST) begin
                                state_n_s[i] = LOCKED;
                                cnt_n_s[i]   = CW'(0);
                            end else begin
                                cnt_n_s[i] = cnt_r[i] + CW'(1);
                            end
                        end else begin
                            cnt_n_s[i]    = CW'(0);
                            offset_n_s[i] = (offset_r[i] == OFF_MAX) ? OW'(0) : offset_r[i] + OW'(1);
                        end
                    end
                    LOCKED:  state_n_s[i] = LOCKED;
                    default: state_n_s[i] = SEARCH;
                endcase
            end else begin
                state_n_s[i] = state_r[i];
            end
            locked_n_s[i] = (state_n_s[i] == LOCKED);
        end
    end

    // Lane state, status flags and the one-cycle output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NL; i++) begin
                state_r[i]  <= SEARCH;
                offset_r[i] <= OW'(0);
                cnt_r[i]    <= CW'(0);
                prev_r[i]   <= {WORD_BITS{1'b0}};
            end
            lane_locked <= {NL{1'b0}};
            aligned     <= 1'b0;
            m.valid     <= 1'b0;
            m.data      <= {(DATA_LANES*WORD_BITS){1'b0}};
            m.sync      <= {WORD_BITS{1'b0}};
        end else begin
            for (int i = 0; i < NL; i++) begin
                state_r[i]  <= state_n_s[i];
                offset_r[i] <= offset_n_s[i];
                cnt_r[i]    <= cnt_n_s[i];
                if (s.valid) begin
                    prev_r[i] <= raw_s[i];
                end
            end
            lane_locked <= locked_n_s;
            aligned     <= &locked_n_s;
            // aligned still holds the pre-update lock state here.
            m.valid     <= s.valid & aligned;
            if (s.valid) begin
                m.data <= window_s[DATA_LANES-1:0];
                m.sync <= window_s[DATA_LANES];
            end
        end
    end
endmodule
